// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, records CDB completions,
// presents the oldest entry to commit and retires it automatically once complete.
module reorder_buffer #(
    parameter  int ROB_SIZE = 8,
    parameter  int TAG_W    = $clog2(ROB_SIZE),
    parameter  int XLEN     = 32,
    parameter  int MEM_W    = 2,
    localparam int ENTRY_W  = 1 + XLEN + MEM_W + XLEN + 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dispatch_valid,
    input  logic [4:0]         dispatch_dest_reg,
    input  logic [MEM_W-1:0]   dispatch_mem_size,
    output logic               dispatch_ready,
    output logic [TAG_W-1:0]   dispatch_tag,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [XLEN-1:0]    cdb_value,
    input  logic [XLEN-1:0]    cdb_dest_addr,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_entry,
    output logic               head_ready,
    output logic [TAG_W:0]     rob_count
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(ROB_SIZE);

    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [ROB_SIZE-1:0] valid_q, complete_q;
    logic [4:0]        dest_reg_q [ROB_SIZE];
    logic [MEM_W-1:0]  mem_size_q [ROB_SIZE];
    logic [XLEN-1:0]   value_q    [ROB_SIZE];
    logic [XLEN-1:0]   addr_q     [ROB_SIZE];
    logic              do_disp, do_cmp, do_ret;

    // Readiness looks at registered count only, so a same-cycle retire never
    // frees a slot for a same-cycle dispatch.
    assign dispatch_ready = (count_q != FULL);
    assign dispatch_tag   = tail_q;
    assign rob_count      = count_q;
    assign do_disp        = dispatch_valid && dispatch_ready;
    assign do_cmp         = cdb_valid && valid_q[cdb_tag];
    assign head_ready     = (count_q != '0) && complete_q[head_q];
    assign do_ret         = head_ready;

    always_comb begin
        head_entry = '0;
        if (count_q != '0)
            head_entry = {1'b1, value_q[head_q], mem_size_q[head_q],
                          addr_q[head_q], dest_reg_q[head_q]};
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_disp) tail_d = tail_q + 1'b1;
            if (do_ret)  head_d = head_q + 1'b1;
            case ({do_disp, do_ret})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar j = 0; j < ROB_SIZE; j++) begin : g_slot
        logic sel_disp, sel_cmp, sel_ret;
        assign sel_disp = do_disp && (tail_q == TAG_W'(j));
        assign sel_cmp  = do_cmp  && (cdb_tag == TAG_W'(j));
        assign sel_ret  = do_ret  && (head_q == TAG_W'(j));

        // Retire takes priority; dispatch and completion never target the same
        // slot since the tail slot is always invalid when dispatch is allowed.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                valid_q[j]    <= 1'b0;
                complete_q[j] <= 1'b0;
                dest_reg_q[j] <= '0;
                mem_size_q[j] <= '0;
                value_q[j]    <= '0;
                addr_q[j]     <= '0;
            end else if (flush) begin
                valid_q[j]    <= 1'b0;
                complete_q[j] <= 1'b0;
            end else if (sel_ret) begin
                valid_q[j]    <= 1'b0;
                complete_q[j] <= 1'b0;
            end else if (sel_disp) begin
                valid_q[j]    <= 1'b1;
                complete_q[j] <= 1'b0;
                dest_reg_q[j] <= dispatch_dest_reg;
                mem_size_q[j] <= dispatch_mem_size;
                value_q[j]    <= '0;
                addr_q[j]     <= '0;
            end else if (sel_cmp) begin
                complete_q[j] <= 1'b1;
                value_q[j]    <= cdb_value;
                addr_q[j]     <= cdb_dest_addr;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based model of the buffer.
module tb_reorder_buffer;

    localparam int ROB  = 8;
    localparam int TW   = 3;
    localparam int XL   = 32;
    localparam int EW   = 1 + XL + 2 + XL + 5;

    logic          clock, reset;
    logic          dispatch_valid;
    logic [4:0]    dispatch_dest_reg;
    logic [1:0]    dispatch_mem_size;
    logic          dispatch_ready;
    logic [TW-1:0] dispatch_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [XL-1:0] cdb_value, cdb_dest_addr;
    logic          flush;
    logic [EW-1:0] head_entry;
    logic          head_ready;
    logic [TW:0]   rob_count;

    int n_vec = 0;
    int n_err = 0;

    reorder_buffer #(.ROB_SIZE(ROB), .XLEN(XL)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_dest_reg(dispatch_dest_reg),
        .dispatch_mem_size(dispatch_mem_size), .dispatch_ready(dispatch_ready),
        .dispatch_tag(dispatch_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_dest_addr(cdb_dest_addr), .flush(flush),
        .head_entry(head_entry), .head_ready(head_ready), .rob_count(rob_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: program-order queue of in-flight entries.
    typedef struct {
        int          tag;
        logic [4:0]  dest;
        logic [1:0]  mem;
        logic        cmp;
        logic [31:0] val;
        logic [31:0] addr;
    } ment_t;
    ment_t mq[$];
    int    mtail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] m_head();
        if (mq.size() == 0) return '0;
        return {1'b1, mq[0].val, mq[0].mem, mq[0].addr, mq[0].dest};
    endfunction

    task automatic model_check();
        chk("dispatch_ready", dispatch_ready, (mq.size() < ROB));
        chk("dispatch_tag", dispatch_tag, mtail);
        chk("rob_count", rob_count, mq.size());
        chk("head_ready", head_ready, (mq.size() > 0) && mq[0].cmp);
        chk("head_entry", head_entry, m_head());
    endtask

    task automatic model_update();
        bit ret;
        int sz;
        if (flush) begin
            mq.delete();
            mtail = 0;
            return;
        end
        sz  = mq.size();
        ret = (sz > 0) && mq[0].cmp;
        if (cdb_valid)
            foreach (mq[i])
                if (mq[i].tag == int'(cdb_tag)) begin
                    mq[i].cmp  = 1'b1;
                    mq[i].val  = cdb_value;
                    mq[i].addr = cdb_dest_addr;
                end
        if (dispatch_valid && sz < ROB) begin
            mq.push_back('{mtail, dispatch_dest_reg, dispatch_mem_size, 1'b0, 32'h0, 32'h0});
            mtail = (mtail + 1) % ROB;
        end
        if (ret) void'(mq.pop_front());
    endtask

    task automatic idle();
        dispatch_valid = 0; dispatch_dest_reg = 0; dispatch_mem_size = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_dest_addr = 0; flush = 0;
    endtask

    task automatic cyc_pre();  @(negedge clock); model_check(); endtask
    task automatic cyc_post(); model_update(); @(posedge clock); #1; endtask
    task automatic step();     cyc_pre(); cyc_post(); endtask

    task automatic disp(input logic [4:0] d);
        idle(); dispatch_valid = 1; dispatch_dest_reg = d; dispatch_mem_size = d[1:0]; step();
    endtask

    task automatic cdb(input int t, input logic [31:0] v);
        idle(); cdb_valid = 1; cdb_tag = TW'(t); cdb_value = v; cdb_dest_addr = ~v; step();
    endtask

    task automatic async_reset_check();
        #2 reset = 0;
        #1;
        chk("arst_count", rob_count, 0);
        chk("arst_head_ready", head_ready, 0);
        chk("arst_ready", dispatch_ready, 1);
        chk("arst_tag", dispatch_tag, 0);
        chk("arst_head_entry", head_entry, 0);
        mq.delete();
        mtail = 0;
        @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
    endtask

    typedef struct packed {
        logic        dv;
        logic [4:0]  dreg;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cval;
        logic [3:0]  e_cnt;
        logic        e_hr;
        logic [2:0]  e_tag;
    } vec_t;
    vec_t vt[16];

    initial begin
        vt[0]  = '{0, 0, 0, 0, 32'h0,    0, 0, 0};
        vt[1]  = '{1, 5, 0, 0, 32'h0,    0, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 32'h1234, 1, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 32'h0,    1, 1, 1};
        vt[4]  = '{0, 0, 0, 0, 32'h0,    0, 0, 1};
        vt[5]  = '{1, 1, 0, 0, 32'h0,    0, 0, 1};
        vt[6]  = '{1, 2, 0, 0, 32'h0,    1, 0, 2};
        vt[7]  = '{1, 3, 0, 0, 32'h0,    2, 0, 3};
        vt[8]  = '{0, 0, 1, 3, 32'hc,    3, 0, 4};
        vt[9]  = '{0, 0, 1, 2, 32'hb,    3, 0, 4};
        vt[10] = '{0, 0, 0, 0, 32'h0,    3, 0, 4};
        vt[11] = '{0, 0, 1, 1, 32'ha,    3, 0, 4};
        vt[12] = '{0, 0, 0, 0, 32'h0,    3, 1, 4};
        vt[13] = '{0, 0, 0, 0, 32'h0,    2, 1, 4};
        vt[14] = '{0, 0, 0, 0, 32'h0,    1, 1, 4};
        vt[15] = '{0, 0, 0, 0, 32'h0,    0, 0, 4};

        idle();
        reset = 0;
        @(negedge clock);
        reset = 1;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++) begin
            idle();
            dispatch_valid = vt[i].dv; dispatch_dest_reg = vt[i].dreg;
            cdb_valid = vt[i].cv; cdb_tag = vt[i].ctag; cdb_value = vt[i].cval;
            cdb_dest_addr = vt[i].cval + 32'h100;
            cyc_pre();
            chk($sformatf("tbl%0d_count", i), rob_count, vt[i].e_cnt);
            chk($sformatf("tbl%0d_head_ready", i), head_ready, vt[i].e_hr);
            chk($sformatf("tbl%0d_tag", i), dispatch_tag, vt[i].e_tag);
            if (i == 3) begin
                chk("tbl3_value", head_entry[EW-2 -: 32], 32'h1234);
                chk("tbl3_dest", head_entry[4:0], 5);
            end
            cyc_post();
        end

        // asynchronous reset with entries in flight
        disp(7); disp(8); disp(9);
        idle();
        async_reset_check();

        // fill, overflow attempt, retire one, wrap the tail
        for (int i = 0; i < ROB; i++) disp(5'(i + 1));
        idle(); dispatch_valid = 1; dispatch_dest_reg = 31;
        cyc_pre();
        chk("full_ready", dispatch_ready, 0);
        chk("full_count", rob_count, 8);
        cyc_post();
        chk("full_ignored", rob_count, 8);
        cdb(0, 32'hbeef);
        idle(); step();
        chk("after_retire_ready", dispatch_ready, 1);
        chk("wrap_tag", dispatch_tag, 0);
        disp(20);
        chk("wrap_tag_next", dispatch_tag, 1);
        chk("refill_count", rob_count, 8);

        // flush with 5 entries (2 complete) plus same-cycle dispatch and CDB write
        idle(); flush = 1; step();
        for (int i = 0; i < 5; i++) disp(5'(i + 2));
        cdb(1, 32'h11); cdb(3, 32'h33);
        idle(); flush = 1; dispatch_valid = 1; dispatch_dest_reg = 9;
        cdb_valid = 1; cdb_tag = 2; cdb_value = 32'h22;
        step();
        chk("flush_count", rob_count, 0);
        chk("flush_valid", head_entry[EW-1], 0);
        chk("flush_tag", dispatch_tag, 0);
        chk("flush_head_ready", head_ready, 0);

        // simultaneous dispatch and retire at count 3
        disp(10); disp(11); disp(12);
        cdb(0, 32'h77);
        idle(); dispatch_valid = 1; dispatch_dest_reg = 13;
        cyc_pre();
        chk("sim_pre_count", rob_count, 3);
        chk("sim_pre_head_dest", head_entry[4:0], 10);
        chk("sim_pre_tag", dispatch_tag, 3);
        cyc_post();
        chk("sim_count", rob_count, 3);
        chk("sim_tag", dispatch_tag, 4);
        chk("sim_head_dest", head_entry[4:0], 11);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            dispatch_valid    = ($urandom_range(0, 9) < 7);
            dispatch_dest_reg = 5'($urandom);
            dispatch_mem_size = 2'($urandom);
            cdb_valid         = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                cdb_tag = TW'($urandom);
            cdb_value     = $urandom;
            cdb_dest_addr = $urandom;
            flush         = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) begin
                idle();
                async_reset_check();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
